// File: rtl/pipe_pkg.sv
// Shared decode definitions: opcodes, FSM states, instruction field positions and ID register
// layout.
package pipe_pkg;

    localparam logic [5:0] OP_NOP   = 6'h00;
    localparam logic [5:0] OP_ALU   = 6'h01;
    localparam logic [5:0] OP_ADDI  = 6'h02;
    localparam logic [5:0] OP_LOAD  = 6'h03;
    localparam logic [5:0] OP_STORE = 6'h04;
    localparam logic [5:0] OP_JMP   = 6'h05;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 26;
    localparam int unsigned RD_MSB  = 25;
    localparam int unsigned RD_LSB  = 21;
    localparam int unsigned RS1_MSB = 20;
    localparam int unsigned RS1_LSB = 16;
    localparam int unsigned RS2_MSB = 15;
    localparam int unsigned RS2_LSB = 11;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StFlush  = 2'd1,
        StHalted = 2'd2
    } state_e;

    typedef struct packed {
        logic        valid;
        logic [15:0] pc;
        logic [5:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [15:0] imm;
    } id_reg_t;

    function automatic logic reads_rs1(input logic [5:0] op);
        return (op == OP_ALU) || (op == OP_ADDI) || (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic reads_rs2(input logic [5:0] op);
        return (op == OP_ALU) || (op == OP_STORE);
    endfunction

    function automatic logic is_defined_op(input logic [5:0] op);
        return (op <= OP_JMP) || (op == OP_HALT);
    endfunction

    function automatic id_reg_t unpack_ins(input logic [31:0] ins, input logic [15:0] pc);
        id_reg_t r;
        r.valid  = 1'b1;
        r.pc     = pc;
        r.opcode = ins[OPC_MSB:OPC_LSB];
        r.rd     = ins[RD_MSB:RD_LSB];
        r.rs1    = ins[RS1_MSB:RS1_LSB];
        r.rs2    = ins[RS2_MSB:RS2_LSB];
        r.imm    = ins[IMM_MSB:IMM_LSB];
        return r;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: flags when the incoming instruction reads the
// destination of a LOAD currently sitting in ID.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic        id_valid,
    input  logic [5:0]  id_opcode,
    input  logic [4:0]  id_rd,
    input  logic [31:0] ins,
    output logic        load_use
);

    logic [5:0] in_op;
    logic [4:0] in_rs1;
    logic [4:0] in_rs2;
    logic       id_is_load;
    logic       unused_ins_bits;

    assign in_op      = ins[OPC_MSB:OPC_LSB];
    assign in_rs1     = ins[RS1_MSB:RS1_LSB];
    assign in_rs2     = ins[RS2_MSB:RS2_LSB];
    assign id_is_load = id_valid && (id_opcode == OP_LOAD) && (id_rd != REG_ZERO);

    assign unused_ins_bits = ^{ins[RD_MSB:RD_LSB], ins[RS2_LSB-1:0]};

    always_comb begin
        load_use = 1'b0;
        if (id_is_load) begin
            load_use = (reads_rs1(in_op) && (in_rs1 == id_rd)) ||
                       (reads_rs2(in_op) && (in_rs2 == id_rd));
        end
    end

endmodule

// File: rtl/instr_decode.sv
// Decode stage: ID pipeline register, jump redirect, wrong-path flush, load-use bubbles, HALT.
// Optional build macro ILLEGAL_OP_TRAP_EN redirects undefined opcodes to TRAP_VEC.
module instr_decode
    import pipe_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter logic [15:0] TRAP_VEC     = 16'h0004
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ins,
    input  logic [15:0] current_address,
    output logic [15:0] jmp_loc,
    output logic        pc_mux_sel,
    output logic        stall,
    output logic        stall_pm,
    output logic        id_valid,
    output logic [15:0] id_pc,
    output logic [5:0]  id_opcode,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [15:0] id_imm,
    output logic        halted
);

    localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    id_reg_t     id_q, id_d;
    logic [15:0] jmp_loc_q, jmp_loc_d;
    logic        pc_mux_sel_q, pc_mux_sel_d;
    logic        halted_q, halted_d;
    logic        load_use;
    logic [5:0]  in_op;
    id_reg_t     in_fields;

    assign in_op     = ins[OPC_MSB:OPC_LSB];
    assign in_fields = unpack_ins(ins, current_address);

`ifndef ILLEGAL_OP_TRAP_EN
    logic unused_trap_vec;
    assign unused_trap_vec = ^TRAP_VEC;
`endif

    hazard_detect u_hazard_detect (
        .id_valid  (id_q.valid),
        .id_opcode (id_q.opcode),
        .id_rd     (id_q.rd),
        .ins       (ins),
        .load_use  (load_use)
    );

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        id_d         = '0;
        jmp_loc_d    = jmp_loc_q;
        pc_mux_sel_d = 1'b0;
        halted_d     = halted_q;
        stall        = 1'b0;

        unique case (state_q)
            StRun: begin
                stall = load_use;
                if (!load_use) begin
                    if (in_op == OP_JMP) begin
                        id_d         = in_fields;
                        pc_mux_sel_d = 1'b1;
                        jmp_loc_d    = in_fields.imm;
                        flush_cnt_d  = '0;
                        state_d      = StFlush;
                    end else if (in_op == OP_HALT) begin
                        id_d     = in_fields;
                        halted_d = 1'b1;
                        state_d  = StHalted;
                    end else if (is_defined_op(in_op)) begin
                        id_d = in_fields;
                    end else begin
`ifdef ILLEGAL_OP_TRAP_EN
                        pc_mux_sel_d = 1'b1;
                        jmp_loc_d    = TRAP_VEC;
                        flush_cnt_d  = '0;
                        state_d      = StFlush;
`endif
                    end
                end
            end
            StFlush: begin
                // Wrong-path fetches become bubbles; no hazard check on them.
                if (flush_cnt_q == FLUSH_LAST) begin
                    flush_cnt_d = '0;
                    state_d     = StRun;
                end else begin
                    flush_cnt_d = flush_cnt_q + 2'd1;
                end
            end
            StHalted: begin
                stall = 1'b1;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    assign stall_pm = stall;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StRun;
            flush_cnt_q  <= '0;
            id_q         <= '0;
            jmp_loc_q    <= '0;
            pc_mux_sel_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            id_q         <= id_d;
            jmp_loc_q    <= jmp_loc_d;
            pc_mux_sel_q <= pc_mux_sel_d;
            halted_q     <= halted_d;
        end
    end

    assign jmp_loc    = jmp_loc_q;
    assign pc_mux_sel = pc_mux_sel_q;
    assign halted     = halted_q;
    assign id_valid   = id_q.valid;
    assign id_pc      = id_q.pc;
    assign id_opcode  = id_q.opcode;
    assign id_rd      = id_q.rd;
    assign id_rs1     = id_q.rs1;
    assign id_rs2     = id_q.rs2;
    assign id_imm     = id_q.imm;

endmodule

// File: tb/tb_instr_decode.sv
// Directed plus randomized bench for instr_decode, checked against a cycle-level
// behavioural model of the decode rules.
module tb_instr_decode;

    localparam int FLUSH_N = 1;
    localparam logic [5:0] NOP = 6'h00, ALU = 6'h01, ADDI = 6'h02, LOAD = 6'h03;
    localparam logic [5:0] STORE = 6'h04, JMP = 6'h05, HALT = 6'h3F, ILL = 6'h2A;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ins;
    logic [15:0] current_address;
    logic [15:0] jmp_loc, id_pc, id_imm;
    logic        pc_mux_sel, stall, stall_pm, id_valid, halted;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rd, id_rs1, id_rs2;

    always #5 clk = ~clk;

    instr_decode #(
        .FLUSH_CYCLES (FLUSH_N),
        .TRAP_VEC     (16'h0004)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ins             (ins),
        .current_address (current_address),
        .jmp_loc         (jmp_loc),
        .pc_mux_sel      (pc_mux_sel),
        .stall           (stall),
        .stall_pm        (stall_pm),
        .id_valid        (id_valid),
        .id_pc           (id_pc),
        .id_opcode       (id_opcode),
        .id_rd           (id_rd),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_imm          (id_imm),
        .halted          (halted)
    );

    int checks = 0;
    int failures = 0;

    // Model of what ID holds plus the pending-flush count and the halt flag.
    bit          m_init = 1'b0;
    bit          m_valid = 1'b0;
    logic [15:0] m_pc = '0, m_imm = '0, m_jmp = '0;
    logic [5:0]  m_op = '0;
    logic [4:0]  m_rd = '0, m_rs1 = '0, m_rs2 = '0;
    bit          m_sel = 1'b0, m_halt = 1'b0;
    int          flush_left = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [15:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    function automatic bit model_hazard(input logic [31:0] i);
        logic [5:0] op;
        bit r1, r2;
        op = i[31:26];
        r1 = (op == ALU) || (op == ADDI) || (op == LOAD) || (op == STORE);
        r2 = (op == ALU) || (op == STORE);
        return m_valid && (m_op == LOAD) && (m_rd != 0) &&
               ((r1 && i[20:16] == m_rd) || (r2 && i[15:11] == m_rd));
    endfunction

    function automatic bit exp_stall(input logic [31:0] i);
        return m_halt || (flush_left == 0 && model_hazard(i));
    endfunction

    task automatic model_edge(input bit rst, input logic [31:0] i, input logic [15:0] a);
        logic [5:0] op;
        bit take;
        op = i[31:26];
        take = 1'b0;
        if (!rst) begin
            m_init = 1'b1; m_valid = 1'b0; m_pc = '0; m_op = '0; m_rd = '0; m_rs1 = '0;
            m_rs2 = '0; m_imm = '0; m_jmp = '0; m_sel = 1'b0; m_halt = 1'b0; flush_left = 0;
            return;
        end
        m_sel = 1'b0;
        if (m_halt) begin
            take = 1'b0;
        end else if (flush_left > 0) begin
            flush_left--;
        end else if (model_hazard(i)) begin
            take = 1'b0;
        end else if (op == JMP) begin
            take = 1'b1; m_sel = 1'b1; m_jmp = i[15:0]; flush_left = FLUSH_N;
        end else if (op == HALT) begin
            take = 1'b1; m_halt = 1'b1;
        end else if (op <= JMP) begin
            take = 1'b1;
        end else begin
`ifdef ILLEGAL_OP_TRAP_EN
            m_sel = 1'b1; m_jmp = 16'h0004; flush_left = FLUSH_N;
`endif
        end
        m_valid = take;
        m_pc  = take ? a : '0;
        m_op  = take ? op : '0;
        m_rd  = take ? i[25:21] : '0;
        m_rs1 = take ? i[20:16] : '0;
        m_rs2 = take ? i[15:11] : '0;
        m_imm = take ? i[15:0] : '0;
    endtask

    task automatic cyc(input bit rst, input logic [31:0] i, input logic [15:0] a);
        bit es;
        reset = rst;
        ins = i;
        current_address = a;
        #1;
        if (m_init) begin
            es = exp_stall(i);
            check("stall", {31'b0, stall}, {31'b0, es});
            check("stall_pm", {31'b0, stall_pm}, {31'b0, es});
        end
        @(posedge clk);
        model_edge(rst, i, a);
        #1;
        check("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
        check("id_pc", {16'b0, id_pc}, {16'b0, m_pc});
        check("id_opcode", {26'b0, id_opcode}, {26'b0, m_op});
        check("id_rd", {27'b0, id_rd}, {27'b0, m_rd});
        check("id_rs1", {27'b0, id_rs1}, {27'b0, m_rs1});
        check("id_rs2", {27'b0, id_rs2}, {27'b0, m_rs2});
        check("id_imm", {16'b0, id_imm}, {16'b0, m_imm});
        check("pc_mux_sel", {31'b0, pc_mux_sel}, {31'b0, m_sel});
        check("halted", {31'b0, halted}, {31'b0, m_halt});
        if (m_sel || !rst) check("jmp_loc", {16'b0, jmp_loc}, {16'b0, m_jmp});
    endtask

    initial begin
        logic [31:0] cur;
        logic [15:0] addr;
        logic [5:0]  op;
        logic [5:0]  tbl [8];
        bit          rst;
        tbl = '{ALU, ADDI, LOAD, LOAD, STORE, JMP, NOP, ALU};

        reset = 1'b0;
        ins = '0;
        current_address = '0;

        // Reset with ALU on the bus, then release.
        cyc(1'b0, mk(ALU, 5'd1, 5'd2, 16'h1800), 16'h0010);
        cyc(1'b0, mk(ALU, 5'd1, 5'd2, 16'h1800), 16'h0010);
        check("rst_valid", {31'b0, id_valid}, 32'd0);
        cyc(1'b1, mk(ALU, 5'd1, 5'd2, 16'h1800), 16'h0010);
        check("rel_pc", {16'b0, id_pc}, 32'h10);

        // Straight-line code.
        cyc(1'b1, mk(ADDI, 5'd4, 5'd1, 16'h0055), 16'h0000);
        cyc(1'b1, mk(ALU, 5'd5, 5'd4, 16'h2000), 16'h0001);
        cyc(1'b1, mk(STORE, 5'd0, 5'd5, 16'h2800), 16'h0002);
        check("store_op", {26'b0, id_opcode}, 32'h4);

        // Load-use on rs2, then LOAD to r0 which must not stall.
        cyc(1'b1, mk(LOAD, 5'd3, 5'd1, 16'h0000), 16'h0003);
        check("lu_stall", {31'b0, stall}, 32'd0);
        cyc(1'b1, mk(ALU, 5'd6, 5'd1, 16'h1800), 16'h0004);
        check("lu_bubble", {31'b0, id_valid}, 32'd0);
        cyc(1'b1, mk(ALU, 5'd6, 5'd1, 16'h1800), 16'h0004);
        check("lu_after", {16'b0, id_pc}, 32'h4);
        cyc(1'b1, mk(LOAD, 5'd0, 5'd1, 16'h0000), 16'h0005);
        cyc(1'b1, mk(ALU, 5'd6, 5'd0, 16'h0000), 16'h0006);
        check("lu_r0", {31'b0, id_valid}, 32'd1);

        // Jump with one wrong-path fetch.
        cyc(1'b1, mk(JMP, 5'd0, 5'd0, 16'h0008), 16'h0002);
        check("jmp_sel", {31'b0, pc_mux_sel}, 32'd1);
        check("jmp_loc_v", {16'b0, jmp_loc}, 32'h8);
        cyc(1'b1, mk(ADDI, 5'd1, 5'd1, 16'h0001), 16'h0003);
        check("flush_bub", {31'b0, id_valid}, 32'd0);
        cyc(1'b1, mk(ADDI, 5'd2, 5'd2, 16'h0002), 16'h0008);
        check("jmp_tgt", {16'b0, id_pc}, 32'h8);

        // Undefined opcode.
        cyc(1'b1, mk(ILL, 5'd1, 5'd1, 16'h0000), 16'h0009);
        cyc(1'b1, mk(NOP, 5'd0, 5'd0, 16'h0000), 16'h000A);
        cyc(1'b1, mk(NOP, 5'd0, 5'd0, 16'h0000), 16'h000B);

        // Reset wins over a pending load-use stall.
        cyc(1'b1, mk(LOAD, 5'd3, 5'd1, 16'h0000), 16'h000C);
        cyc(1'b0, mk(ADDI, 5'd1, 5'd3, 16'h0000), 16'h000D);
        cyc(1'b1, mk(ADDI, 5'd1, 5'd3, 16'h0000), 16'h000D);

        // HALT held, then cleared by reset.
        cyc(1'b1, mk(HALT, 5'd0, 5'd0, 16'h0000), 16'h000E);
        for (int k = 0; k < 6; k++) cyc(1'b1, mk(ALU, 5'd1, 5'd2, 16'h0000), 16'h000F);
        check("halt_hold", {30'b0, halted, stall}, 32'd3);
        cyc(1'b0, mk(ALU, 5'd1, 5'd2, 16'h0000), 16'h000F);
        check("halt_rst", {30'b0, halted, id_valid}, 32'd0);

        // Randomized traffic; stalled instructions are re-presented unchanged.
        addr = 16'h0020;
        cur = mk(NOP, 5'd0, 5'd0, 16'h0000);
        for (int n = 0; n < 600; n++) begin
            rst = !(($urandom_range(0, 63) == 0) || (m_halt && $urandom_range(0, 3) == 0));
            if (!(rst && m_init && exp_stall(cur))) begin
                case ($urandom_range(0, 31))
                    0:       op = HALT;
                    1, 2:    op = 6'($urandom_range(6, 62));
                    default: op = tbl[$urandom_range(0, 7)];
                endcase
                cur = mk(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                         {5'($urandom_range(0, 3)), 11'($urandom)});
                addr = addr + 16'd1;
            end
            cyc(rst, cur, addr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
